spi_slave_rx: RTL and testbench
===============================

Name: spi_slave_rx

Overview:
- SPI receiver (slave side), mode 0: SCK idles low, MOSI sampled on SCK rising edge, MSB first.
- Pairs with the team's spi_master transmitter. Oversamples the external SCK/MOSI/CS_n with the system clock, deserialises DATA_WIDTH-bit words and presents each word with a valid strobe to the local logic.
- Flags words truncated by CS_n deassertion.

Parameters:
- DATA_WIDTH, 8, bits per word; legal range 2..32.
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser; legal range 2..4.

Ports:
- clk  input  1  system clock; must run at least 4x the SCK frequency.
- reset  input  1  synchronous, active-high reset.
- SCK  input  1  SPI clock from master, asynchronous to clk.
- MOSI  input  1  serial data from master, asynchronous to clk.
- CS_n  input  1  active-low chip select, asynchronous to clk.
- data_out  output  DATA_WIDTH  last completed word, MSB = first bit received.
- data_valid  output  1  new word available on data_out (see Optional Feature for duration).
- busy  output  1  high while a word is partially received.
- frame_err  output  1  one-cycle pulse when a word is truncated by CS_n.

Behaviour:
- Reset (synchronous, active-high, checked on rising clk):
  - data_out = 0, data_valid = 0, busy = 0, frame_err = 0.
  - Bit counter = 0, shift register = 0, state = IDLE.
  - Synchroniser flops load their idle values: SCK = 0, MOSI = 0, CS_n = 1.
- Synchronisation:
  - SCK, MOSI and CS_n each pass through SYNC_STAGES flops; all three use equal depth so their relative timing is preserved.
  - One extra flop on synchronised SCK (sck_d) feeds edge detection.
  - sck_rise = sync_sck & ~sck_d.
- State machine:
  - IDLE: wait for synchronised CS_n = 0, then go to RECV with bit_cnt = 0.
  - RECV, on sck_rise: shift_reg <= {shift_reg[DATA_WIDTH-2:0], sync_mosi}; bit_cnt + 1.
  - RECV, when bit_cnt == DATA_WIDTH-1 at a sck_rise: on the next cycle data_out <= completed word, data_valid asserts, bit_cnt wraps to 0, and the state stays RECV. This allows back-to-back words under one CS_n assertion.
  - RECV, synchronised CS_n = 1: go to IDLE. If bit_cnt != 0, pulse frame_err for one cycle; data_out is left unchanged and partial bits are discarded.
- busy = (state == RECV) && (bit_cnt != 0).
- Latency: data_valid rises SYNC_STAGES+2 clk cycles after the final SCK rising edge reaches the pin.
- sck_rise while synchronised CS_n = 1 is ignored.
- CS_n deasserting in the same cycle as the final sck_rise: the word completes and data_valid asserts; frame_err does not pulse.
- Reset asserted mid-word: all state is cleared, no data_valid, no frame_err.
- MOSI is not checked for stability; the master must hold MOSI stable for at least SYNC_STAGES+1 clk cycles around each SCK rising edge.

Optional Feature:
- Macro: SPI_SLAVE_RX_ACK_EN.
- Defined:
  - Adds input data_ack (1 bit) and output overrun (1 bit, reset 0).
  - data_valid stays high until a cycle with data_ack = 1 clears it on the following cycle.
  - A word completing while data_valid is still high does not overwrite data_out; the word is dropped and overrun pulses for one cycle.
  - A word completing in the same cycle that data_ack is high is accepted: data_out updates and data_valid stays high.
- Undefined:
  - No data_ack or overrun ports.
  - data_valid is a single-cycle pulse per word; data_out holds until the next word completes.

Test Plan:
- Reset, then CS_n low, send 0xA5 MSB first at clk/8 SCK, CS_n high -> data_out = 0xA5, one data_valid pulse, frame_err stays 0.
- One CS_n window carrying 0x3C then 0xFF back-to-back -> two data_valid pulses, data_out = 0x3C then 0xFF, busy low between words.
- CS_n low, 5 SCK edges, CS_n high -> frame_err pulses once, data_valid stays 0, data_out keeps its previous value, next frame 0x81 is received correctly.
- Reset asserted after 4 bits of 0xF0 -> all outputs 0; new frame 0x0F then gives data_out = 0x0F.
- SCK toggling with CS_n high -> no data_valid, busy stays 0.
- SPI_SLAVE_RX_ACK_EN, data_ack held 0, send 0x11 then 0x22 -> data_out = 0x11, overrun pulses once; then pulse data_ack -> data_valid clears on the next cycle.

Source files
------------

// File: rtl/spi_slave_rx.sv
// spi_slave_rx -- SPI mode 0 slave receiver (SCK idles low, MOSI sampled on
// SCK rising edge, MSB first). SCK/MOSI/CS_n are oversampled by clk through
// equal-depth synchronisers, words of DATA_WIDTH bits are deserialised and
// handed to local logic with a valid strobe. Words cut short by CS_n
// deassertion are discarded and flagged with frame_err.
//
// Optional feature macro: SPI_SLAVE_RX_ACK_EN
//   undefined : data_valid is a one-cycle pulse per word.
//   defined   : adds data_ack/overrun; data_valid holds until acknowledged,
//               words arriving while unacknowledged are dropped (overrun).
//
// Ports:
//   clk        system clock (>= 4x SCK)
//   reset      synchronous active-high reset
//   SCK        SPI clock from master (async)
//   MOSI       serial data from master (async)
//   CS_n       active-low chip select (async)
//   data_ack   (ACK_EN only) consumer accepted data_out
//   overrun    (ACK_EN only) one-cycle pulse, word dropped
//   data_out   last completed word, MSB = first bit received
//   data_valid new word available on data_out
//   busy       word partially received
//   frame_err  one-cycle pulse, word truncated by CS_n
module spi_slave_rx #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  SCK,
   input  logic                  MOSI,
   input  logic                  CS_n,
`ifdef SPI_SLAVE_RX_ACK_EN
   input  logic                  data_ack,
   output logic                  overrun,
`endif
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  busy,
   output logic                  frame_err
);

   localparam int            CW   = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   typedef enum logic {IDLE, RECV} state_t;

   logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, cs_sync;
   logic                   sck_d;
   logic                   sync_sck, sync_mosi, sync_cs_n;
   logic                   sck_rise, final_bit;

   state_t                 state;
   logic [CW-1:0]          bit_cnt;
   logic [DATA_WIDTH-1:0]  shift_reg;
   logic                   word_done;

   // All three inputs share one depth so MOSI/CS_n stay aligned with SCK.
   always_ff @(posedge clk) begin
      if (reset) begin
         sck_sync  <= '0;
         mosi_sync <= '0;
         cs_sync   <= '1;
         sck_d     <= 1'b0;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS_n};
         sck_d     <= sck_sync[SYNC_STAGES-1];
      end
   end

   assign sync_sck  = sck_sync[SYNC_STAGES-1];
   assign sync_mosi = mosi_sync[SYNC_STAGES-1];
   assign sync_cs_n = cs_sync[SYNC_STAGES-1];
   assign sck_rise  = sync_sck & ~sck_d;
   assign final_bit = sck_rise && (bit_cnt == LAST);

   assign busy = (state == RECV) && (bit_cnt != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         word_done  <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
`ifdef SPI_SLAVE_RX_ACK_EN
         overrun    <= 1'b0;
`endif
      end else begin
         frame_err <= 1'b0;
         word_done <= 1'b0;
`ifdef SPI_SLAVE_RX_ACK_EN
         overrun   <= 1'b0;
`endif
         case (state)
            IDLE: begin
               bit_cnt <= '0;
               if (!sync_cs_n) state <= RECV;
            end
            RECV: begin
               if (sync_cs_n && !final_bit) begin
                  // Abort: partial bits are dropped, data_out untouched.
                  state     <= IDLE;
                  bit_cnt   <= '0;
                  frame_err <= (bit_cnt != '0);
               end else begin
                  // A final edge coinciding with CS_n release still completes.
                  if (sync_cs_n) state <= IDLE;
                  if (sck_rise) begin
                     shift_reg <= {shift_reg[DATA_WIDTH-2:0], sync_mosi};
                     bit_cnt   <= final_bit ? '0 : bit_cnt + 1'b1;
                     word_done <= final_bit;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         // Hand-off stage one cycle after the last shift, independent of
         // state so a completion racing CS_n release is not lost.
`ifdef SPI_SLAVE_RX_ACK_EN
         if (word_done) begin
            if (data_valid && !data_ack) begin
               overrun <= 1'b1;
            end else begin
               data_out   <= shift_reg;
               data_valid <= 1'b1;
            end
         end else if (data_ack) begin
            data_valid <= 1'b0;
         end
`else
         data_valid <= word_done;
         if (word_done) data_out <= shift_reg;
`endif
      end
   end

endmodule

// File: tb/tb_spi_slave_rx.sv
module tb_spi_slave_rx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       SCK = 1'b0;
   logic       MOSI = 1'b0;
   logic       CS_n = 1'b1;
   logic [7:0] data_out;
   logic       data_valid, busy, frame_err;
`ifdef SPI_SLAVE_RX_ACK_EN
   logic       data_ack = 1'b1;
   logic       overrun;
`endif

   int         checks = 0;
   int         failures = 0;
   logic [7:0] exp_q[$];
   int         fe_exp = 0;
   int         ov_exp = 0;
   bit         no_busy = 0;
   bit         busy_seen = 0;
   bit         vld_q = 0;
   bit         stim_done = 0;

   spi_slave_rx #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .SCK(SCK), .MOSI(MOSI), .CS_n(CS_n),
`ifdef SPI_SLAVE_RX_ACK_EN
      .data_ack(data_ack), .overrun(overrun),
`endif
      .data_out(data_out), .data_valid(data_valid), .busy(busy),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // clk/8 SCK; MOSI changes on SCK fall so it is stable around each rise.
   task automatic send_bits(input logic [7:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         MOSI = v[7-i];
         tick(4);
         SCK = 1'b1;
         tick(4);
         SCK = 1'b0;
      end
   endtask

   task automatic frame(input logic [7:0] v);
      exp_q.push_back(v);
      CS_n = 1'b0;
      tick(6);
      send_bits(v, 8);
      tick(6);
      CS_n = 1'b1;
      tick(10);
   endtask

   task automatic drain(input string name);
      for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick(1);
      check(name, exp_q.size(), 0);
   endtask

   initial begin
      fork
         // Monitor: pops the scoreboard on each new data_valid.
         begin
            while (!stim_done) begin
               @(negedge clk);
               if (data_valid && !vld_q) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     failures++;
                     $display("FAIL unexpected_valid actual=%0h required=none", data_out);
                  end else begin
                     logic [7:0] e;
                     e = exp_q.pop_front();
                     if (data_out !== e) begin
                        failures++;
                        $display("FAIL data_out actual=%0h required=%0h", data_out, e);
                     end
                  end
               end
`ifndef SPI_SLAVE_RX_ACK_EN
               if (data_valid && vld_q) begin
                  checks++;
                  failures++;
                  $display("FAIL valid_width actual=2+ required=1");
               end
`else
               if (overrun) begin
                  checks++;
                  if (ov_exp == 0) begin
                     failures++;
                     $display("FAIL unexpected_overrun actual=1 required=0");
                  end else ov_exp--;
               end
`endif
               if (frame_err) begin
                  checks++;
                  if (fe_exp == 0) begin
                     failures++;
                     $display("FAIL unexpected_frame_err actual=1 required=0");
                  end else fe_exp--;
               end
               if (no_busy && busy) busy_seen = 1;
               vld_q = data_valid;
            end
         end
         // Stimulus
         begin
            tick(3);
            check("rst_data_out", data_out, 0);
            check("rst_data_valid", data_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_frame_err", frame_err, 0);
            reset = 1'b0;
            tick(4);

            frame(8'hA5);
            drain("a5_drain");
            check("a5_data_out", data_out, 8'hA5);

            // Back-to-back words under one CS_n
            exp_q.push_back(8'h3C);
            exp_q.push_back(8'hFF);
            CS_n = 1'b0;
            tick(6);
            send_bits(8'h3C, 8);
            check("busy_between", busy, 0);
            send_bits(8'hFF, 8);
            tick(6);
            CS_n = 1'b1;
            tick(10);
            drain("b2b_drain");
            check("b2b_data_out", data_out, 8'hFF);

            // Truncated word
            CS_n = 1'b0;
            tick(6);
            send_bits(8'hAA, 5);
            tick(2);
            check("busy_mid", busy, 1);
            fe_exp = 1;
            CS_n = 1'b1;
            tick(12);
            check("frame_err_seen", fe_exp, 0);
            check("trunc_hold", data_out, 8'hFF);
            frame(8'h81);
            drain("81_drain");

            // Reset mid-word
            CS_n = 1'b0;
            tick(6);
            send_bits(8'hF0, 4);
            reset = 1'b1;
            CS_n = 1'b1;
            tick(2);
            check("mid_rst_data_out", data_out, 0);
            check("mid_rst_valid", data_valid, 0);
            check("mid_rst_busy", busy, 0);
            check("mid_rst_frame_err", frame_err, 0);
            reset = 1'b0;
            tick(4);
            frame(8'h0F);
            drain("0f_drain");
            check("0f_data_out", data_out, 8'h0F);

            // SCK activity with CS_n high is ignored
            busy_seen = 0;
            no_busy = 1;
            send_bits(8'h5A, 8);
            tick(10);
            no_busy = 0;
            check("no_cs_busy", busy_seen, 0);
            check("no_cs_data_out", data_out, 8'h0F);

`ifdef SPI_SLAVE_RX_ACK_EN
            data_ack = 1'b0;
            exp_q.push_back(8'h11);
            ov_exp = 1;
            CS_n = 1'b0;
            tick(6);
            send_bits(8'h11, 8);
            send_bits(8'h22, 8);
            tick(6);
            CS_n = 1'b1;
            tick(10);
            drain("ack_drain");
            check("overrun_seen", ov_exp, 0);
            check("ack_data_out", data_out, 8'h11);
            check("ack_valid_held", data_valid, 1);
            data_ack = 1'b1;
            tick(1);
            data_ack = 1'b0;
            check("ack_valid_clr", data_valid, 0);
            tick(4);
`endif
            check("final_queue", exp_q.size(), 0);
            stim_done = 1;
         end
      join
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
